// File: rtl/vc_dest_arbiter_pkg.sv
// Transaction-layer constants shared by the VC-to-destination arbiter and its helpers.
package vc_dest_arbiter_pkg;

    localparam int TL_DATA_W       = 6;
    localparam int TL_DEST_BIT     = 4;
    localparam int TL_STARVE_LIMIT = 3;
    localparam int TL_CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_ERROR = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_VC0  = 2'b01;
    localparam logic [1:0] GNT_VC1  = 2'b10;

endpackage

// File: rtl/vc_starve_counter.sv
// Saturating count of VC0 grants taken while VC1 was waiting; flags when VC1 must be forced.
module vc_starve_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic hold_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // hold wins over clear so a disabled arbiter keeps its fairness history
    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (inc_i && (cnt_q != LIMIT_C)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/vc_dest_arbiter.sv
// Pops one eligible VC head per cycle (VC0 priority, VC1 starvation-bounded) and pushes it
// one cycle later into the destination FIFO selected by its destination bit.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int DATA_W       = TL_DATA_W,
    parameter int DEST_BIT     = TL_DEST_BIT,
    parameter int STARVE_LIMIT = TL_STARVE_LIMIT,
    parameter int CNT_W        = TL_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    input  logic              d0_full,
    input  logic              d1_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic              d1_push,
    output logic [DATA_W-1:0] d_data,
    output logic [1:0]        grant,
    output logic              error_out,
    output arb_state_e        state_o
);

    arb_state_e        state_q, state_d;
    logic              d0_push_q, d0_push_d;
    logic              d1_push_q, d1_push_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic [1:0]        grant_q, grant_d;

    logic              in_error;
    logic              af0, af1;
    logic              elig0, elig1;
    logic              at_limit;
    logic              gnt0, gnt1, any_gnt;
    logic [DATA_W-1:0] sel_data;
    logic              sel_dest;
    logic              overflow;

    assign in_error = (state_q == ST_ERROR);

    // each VC is blocked by the almost-full flag of the FIFO its head word is heading to
    assign af0   = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign af1   = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
    assign elig0 = enable & ~vc0_empty & ~af0 & ~in_error;
    assign elig1 = enable & ~vc1_empty & ~af1 & ~in_error;

    assign gnt0    = elig0 & ~(elig1 & at_limit);
    assign gnt1    = elig1 & (~elig0 | at_limit);
    assign any_gnt = gnt0 | gnt1;

    assign sel_data = gnt1 ? vc1_data : vc0_data;
    assign sel_dest = sel_data[DEST_BIT];
    assign overflow = any_gnt & (sel_dest ? d1_full : d0_full);

    vc_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_ni     (reset),
        .hold_i     (~enable),
        .clr_i      (gnt1 | ~elig1),
        .inc_i      (gnt0 & elig1),
        .at_limit_o (at_limit)
    );

    always_comb begin
        state_d   = state_q;
        d0_push_d = 1'b0;
        d1_push_d = 1'b0;
        d_data_d  = d_data_q;
        grant_d   = GNT_NONE;

        if (any_gnt) begin
            d_data_d = sel_data;
            grant_d  = gnt1 ? GNT_VC1 : GNT_VC0;
            // a word aimed at a full FIFO is dropped and latches the error
            if (!overflow) begin
                d0_push_d = ~sel_dest;
                d1_push_d = sel_dest;
            end
        end

        case (state_q)
            ST_ERROR: state_d = ST_ERROR;
            default: begin
                if (overflow) begin
                    state_d = ST_ERROR;
                end else if (any_gnt) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            d_data_q  <= '0;
            grant_q   <= GNT_NONE;
        end else begin
            state_q   <= state_d;
            d0_push_q <= d0_push_d;
            d1_push_q <= d1_push_d;
            d_data_q  <= d_data_d;
            grant_q   <= grant_d;
        end
    end

    assign vc0_pop   = gnt0 & reset;
    assign vc1_pop   = gnt1 & reset;
    assign d0_push   = d0_push_q;
    assign d1_push   = d1_push_q;
    assign d_data    = d_data_q;
    assign grant     = grant_q;
    assign error_out = in_error;
    assign state_o   = state_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: a per-cycle vector table plus hand-written reset/overflow sequences.
module tb_vc_dest_arbiter;
    import vc_dest_arbiter_pkg::*;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full;
    logic          d0_full, d1_full;
    logic          vc0_pop, vc1_pop;
    logic          d0_push, d1_push;
    logic [DW-1:0] d_data;
    logic [1:0]    grant;
    logic          error_out;
    arb_state_e    state_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vc_dest_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d0_full        (d0_full),
        .d1_full        (d1_full),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .d_data         (d_data),
        .grant          (grant),
        .error_out      (error_out),
        .state_o        (state_o)
    );

    typedef struct {
        logic          en, e0, e1;
        logic [DW-1:0] d0, d1;
        logic          af0, af1;
        logic          p0, p1, dp0, dp1;
        logic [DW-1:0] dd;
        logic [1:0]    g;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic e0, logic e1, logic [DW-1:0] d0, logic [DW-1:0] d1,
                                logic af0, logic af1, logic p0, logic p1, logic dp0, logic dp1,
                                logic [DW-1:0] dd, logic [1:0] g);
        vec_t v;
        v.en = en; v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1; v.af0 = af0; v.af1 = af1;
        v.p0 = p0; v.p1 = p1; v.dp0 = dp0; v.dp1 = dp1; v.dd = dd; v.g = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic e0, input logic e1, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic af0, input logic af1,
                         input logic f0, input logic f1);
        enable = en; vc0_empty = e0; vc1_empty = e1; vc0_data = d0; vc1_data = d1;
        d0_almost_full = af0; d1_almost_full = af1; d0_full = f0; d1_full = f1;
    endtask

    task automatic check_regs(input string tag, input logic dp0, input logic dp1,
                              input logic [DW-1:0] dd, input logic [1:0] g, input logic err);
        chk({tag, " d0_push"}, 32'(d0_push), 32'(dp0));
        chk({tag, " d1_push"}, 32'(d1_push), 32'(dp1));
        chk({tag, " d_data"}, 32'(d_data), 32'(dd));
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " error_out"}, 32'(error_out), 32'(err));
    endtask

    initial begin
        // after the bench reset: cnt=1 (VC0 granted while VC1 eligible), d_data=5
        tbl.push_back(mk(1, 0, 1, 6'd21, 6'd0,  0, 0, 1, 0, 0, 1, 6'd21, GNT_VC0));
        tbl.push_back(mk(1, 1, 1, 6'd0,  6'd0,  0, 0, 0, 0, 0, 0, 6'd21, GNT_NONE));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 1, 0, 1, 0, 6'd5,  GNT_VC0));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 1, 0, 1, 0, 6'd5,  GNT_VC0));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 1, 0, 1, 0, 6'd5,  GNT_VC0));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 0, 1, 1, 0, 6'd10, GNT_VC1));
        tbl.push_back(mk(1, 0, 0, 6'd6,  6'd10, 0, 0, 1, 0, 1, 0, 6'd6,  GNT_VC0));
        tbl.push_back(mk(1, 0, 0, 6'd6,  6'd10, 0, 0, 1, 0, 1, 0, 6'd6,  GNT_VC0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 6'd5, 6'd10, 0, 0, 0, 0, 0, 0, 6'd6, GNT_NONE));
        // counter held at 2 across the gap: one more VC0, then VC1 forced
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 1, 0, 1, 0, 6'd5,  GNT_VC0));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd10, 0, 0, 0, 1, 1, 0, 6'd10, GNT_VC1));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd21, 1, 0, 0, 1, 0, 1, 6'd21, GNT_VC1));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd19, 1, 0, 0, 1, 0, 1, 6'd19, GNT_VC1));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd21, 1, 0, 0, 1, 0, 1, 6'd21, GNT_VC1));
        tbl.push_back(mk(1, 0, 0, 6'd5,  6'd21, 0, 0, 1, 0, 1, 0, 6'd5,  GNT_VC0));
        tbl.push_back(mk(1, 1, 0, 6'd5,  6'd21, 0, 1, 0, 0, 0, 0, 6'd5,  GNT_NONE));
        tbl.push_back(mk(1, 0, 1, 6'd21, 6'd0,  0, 1, 0, 0, 0, 0, 6'd5,  GNT_NONE));
        tbl.push_back(mk(1, 0, 0, 6'd21, 6'd10, 0, 0, 1, 0, 0, 1, 6'd21, GNT_VC0));

        // reset held with both VCs non-empty
        reset = 1'b0;
        drive(1, 0, 0, 6'd5, 6'd10, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst vc0_pop", 32'(vc0_pop), 32'd0);
        chk("rst vc1_pop", 32'(vc1_pop), 32'd0);
        chk("rst state", 32'(state_o), 32'(ST_IDLE));
        check_regs("rst", 0, 0, 6'd0, GNT_NONE, 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel vc0_pop", 32'(vc0_pop), 32'd1);
        chk("rel vc1_pop", 32'(vc1_pop), 32'd0);
        @(posedge clk);
        #1;
        check_regs("rel", 1, 0, 6'd5, GNT_VC0, 0);
        chk("rel state", 32'(state_o), 32'(ST_SERVE));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(tbl[i].en, tbl[i].e0, tbl[i].e1, tbl[i].d0, tbl[i].d1, tbl[i].af0, tbl[i].af1, 0, 0);
            #1;
            chk({tag, " vc0_pop"}, 32'(vc0_pop), 32'(tbl[i].p0));
            chk({tag, " vc1_pop"}, 32'(vc1_pop), 32'(tbl[i].p1));
            @(posedge clk);
            #1;
            check_regs(tag, tbl[i].dp0, tbl[i].dp1, tbl[i].dd, tbl[i].g, 0);
        end

        // overflow: VC1 head to D1 while D1 is full but not almost-full
        @(negedge clk);
        drive(1, 1, 0, 6'd5, 6'd21, 0, 0, 0, 1);
        #1;
        chk("ovf vc1_pop", 32'(vc1_pop), 32'd1);
        @(posedge clk);
        #1;
        chk("ovf error_out", 32'(error_out), 32'd1);
        chk("ovf d1_push", 32'(d1_push), 32'd0);
        chk("ovf d0_push", 32'(d0_push), 32'd0);
        chk("ovf state", 32'(state_o), 32'(ST_ERROR));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1, 0, 0, 6'd5, 6'd21, 0, 0, 0, 0);
            #1;
            chk("err vc0_pop", 32'(vc0_pop), 32'd0);
            chk("err vc1_pop", 32'(vc1_pop), 32'd0);
            @(posedge clk);
            #1;
            chk("err d0_push", 32'(d0_push), 32'd0);
            chk("err d1_push", 32'(d1_push), 32'd0);
            chk("err sticky", 32'(error_out), 32'd1);
        end

        // reset clears the error
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("clr error_out", 32'(error_out), 32'd0);
        chk("clr state", 32'(state_o), 32'(ST_IDLE));

        // reset asserted while a word is being popped: it must never be pushed
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 1, 6'd21, 6'd0, 0, 0, 0, 0);
        #1;
        chk("mid vc0_pop", 32'(vc0_pop), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid pop held", 32'(vc0_pop), 32'd0);
        @(posedge clk);
        #1;
        check_regs("mid", 0, 0, 6'd0, GNT_NONE, 0);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_regs("post", 0, 1, 6'd21, GNT_VC0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transaction layer.
- Each cycle it picks at most one eligible VC head word and pops it. It routes the word to D0 or D1 by its destination bit and pushes it one cycle later.
- VC0 is the priority channel; a starvation counter bounds VC1 waiting time.
- VC FIFOs are first-word-fall-through: head data is valid whenever not empty.

Parameters:
- DATA_W, 6, word width; must match VC/D FIFOs.
- DEST_BIT, 4, index of the bit in the word that selects the destination (0 → D0, 1 → D1).
- STARVE_LIMIT, 3, consecutive VC0 grants allowed while VC1 is eligible before VC1 is forced; range 1..15.
- CNT_W, 4, starvation counter width.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration enable; 0 freezes grants.
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  DATA_W  VC0 head word.
- vc1_data  input  DATA_W  VC1 head word.
- d0_almost_full  input  1  D0 above its full threshold.
- d1_almost_full  input  1  D1 above its full threshold.
- d0_full  input  1  D0 completely full.
- d1_full  input  1  D1 completely full.
- vc0_pop  output  1  pop VC0 (combinational, same cycle as grant).
- vc1_pop  output  1  pop VC1 (combinational).
- d0_push  output  1  push D0 (registered).
- d1_push  output  1  push D1 (registered).
- d_data  output  DATA_W  word to D FIFOs (registered, shared bus).
- grant  output  2  registered one-hot of last grant: 01 = VC0, 10 = VC1, 00 = none.
- error_out  output  1  sticky overflow error.

Behaviour:
- Reset (reset = 0, async): d0_push = d1_push = 0, d_data = 0, grant = 00, error_out = 0, starvation counter = 0, state = IDLE.
- vcX_pop is held 0 while reset is low.
- Eligibility: eligX = enable & !vcX_empty & !almost_full of D[vcX_data[DEST_BIT]] & !error_out.
- States:
  - IDLE: no eligible VC.
  - SERVE: a grant is issued this cycle.
  - Transitions are evaluated every cycle from the eligibility signals.
  - ERROR is absorbing until reset.
- Grant rule:
  - If only one VC is eligible, grant it.
  - If both are eligible, grant VC0 unless the counter equals STARVE_LIMIT; then grant VC1.
- Counter:
  - Increments on each VC0 grant made while VC1 is eligible.
  - Clears on any VC1 grant, or when VC1 is not eligible.
  - Saturates at STARVE_LIMIT.
- Grant cycle t: vcX_pop = 1 combinationally.
- At edge t+1: d_data ← vcX_data; dY_push ← 1 for Y = vcX_data[DEST_BIT], other push ← 0; grant ← one-hot X.
- No grant: both pushes go 0 next edge; d_data holds its value.
- Latency 1 cycle pop→push. Throughput 1 word/cycle.
- Back-to-back pops of the same VC are allowed (FWFT head updates at the pop edge).
- The almost_full thresholds must leave ≥1 free slot for the in-flight word; the arbiter does not compensate.
- Overflow: if dY_push would be asserted at an edge while dY_full = 1, set error_out = 1, suppress that push, and enter ERROR. In ERROR, no further pops are issued.
- enable deasserted mid-stream: the in-flight push still completes next cycle, then outputs go idle. The counter holds its value.
- Reset mid-transfer: the in-flight word is dropped, with no push.

Decomposition:
- Shared transaction-layer package: DATA_W, DEST_BIT, state encoding (IDLE, SERVE, ERROR), grant encoding constants.
- One natural sub-module: vc_starve_counter (saturating counter with clear/inc/limit compare).
- Grant logic and output registers stay in the top module.

Test Plan:
- Reset: hold reset = 0 with both VCs non-empty → all outputs 0, no pops. Release reset → first grant VC0 in the next cycle.
- Routing: VC0 head 6'b010101 (bit4 = 1), VC1 empty → vc0_pop = 1 at t; d1_push = 1 and d_data = 21 at t+1; d0_push = 0.
- Starvation: both VCs continuously non-empty with destination D0, STARVE_LIMIT = 3 → grant pattern VC0, VC0, VC0, VC1, repeating.
- Back-pressure: VC0 head → D0 with d0_almost_full = 1, VC1 head → D1 → VC1 granted every cycle, VC0 never popped. Drop d0_almost_full → VC0 granted next cycle.
- Overflow: force d1_full = 1 with d1_almost_full = 0, VC1 head → D1 → error_out = 1 at the push edge, d1_push stays 0, no further pops until reset.
- Enable toggle: enable = 0 for 5 cycles mid-stream → exactly one trailing push, then zero pops; counter value is preserved across the gap.
